sha2_compress_core: RTL

// - Parametrised SHA-224/SHA-256 compression engine. Consumes expanded message words W[t] from the message scheduler and computes the 64 rounds, UNROLL rounds per clock.
// - Keeps the chaining hash H0..H7 across blocks, so multi-block messages need no external state.
// - Returns the digest as a serial 32-bit word stream with a valid/ready handshake.
// - Sits between the message scheduler and the digest/UART output stage.

---
 rtl/sha2_compress_core.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sha2_compress_core.sv
// SHA-224/SHA-256 compression engine: UNROLL rounds per clock, chaining hash kept
// on chip, digest streamed out as 32-bit words with a valid/ready handshake.
module sha2_compress_core #(
    parameter int DATA_WIDTH = 32,
    parameter int UNROLL     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_in,
    input  logic                         first_in,
    input  logic                         mode_in,
    input  logic                         w_valid_in,
    input  logic [UNROLL*DATA_WIDTH-1:0] w_in,
    output logic                         w_ready_out,
    output logic [5:0]                   round_out,
    output logic                         busy_out,
    output logic                         digest_valid_out,
    output logic [DATA_WIDTH-1:0]        digest_out,
    output logic                         digest_last_out,
    input  logic                         digest_ready_in
);

    if (DATA_WIDTH != 32) begin : gen_bad_width
        $error("sha2_compress_core: DATA_WIDTH must be 32");
    end
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : gen_bad_unroll
        $error("sha2_compress_core: UNROLL must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, SEND} state_t;

    // Packed hash words: element 0 is H0 / working variable a.
    localparam logic [7:0][31:0] IV256 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam logic [7:0][31:0] IV224 = {
        32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
        32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};

    localparam logic [31:0] K_TAB [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ep0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] ep1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    state_t           state_reg;
    state_t           state_next;
    logic [7:0][31:0] work_reg;
    logic [7:0][31:0] hash_reg;
    logic             mode_reg;
    logic [5:0]       t_reg;
    logic [2:0]       cnt_reg;
    logic             last_word;
    logic [7:0][31:0] iv_sel;
    logic [7:0][31:0] chain [0:UNROLL];

    assign iv_sel    = mode_in ? IV224 : IV256;
    assign last_word = (cnt_reg == (mode_reg ? 3'd6 : 3'd7));
    assign round_out = t_reg;
    assign chain[0]  = work_reg;

    // Combinational chain of UNROLL rounds; stage gi uses K[t+gi] and W[t+gi].
    for (genvar gi = 0; gi < UNROLL; gi++) begin : gen_round
        logic [5:0]  k_idx;
        logic [31:0] t1;
        logic [31:0] t2;
        assign k_idx = t_reg + 6'(gi);
        assign t1 = chain[gi][7] + ep1(chain[gi][4]) + ch(chain[gi][4], chain[gi][5], chain[gi][6])
                  + K_TAB[k_idx] + w_in[gi*DATA_WIDTH +: 32];
        assign t2 = ep0(chain[gi][0]) + maj(chain[gi][0], chain[gi][1], chain[gi][2]);
        assign chain[gi+1] = {chain[gi][6:4], chain[gi][3] + t1, chain[gi][2:0], t1 + t2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        w_ready_out      = 1'b0;
        busy_out         = (state_reg != IDLE);
        digest_valid_out = 1'b0;
        digest_out       = '0;
        digest_last_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_in) state_next = ROUND;
            end
            ROUND: begin
                w_ready_out = 1'b1;
                if (w_valid_in && t_reg == 6'(64 - UNROLL)) state_next = FINAL;
            end
            FINAL: state_next = SEND;
            SEND: begin
                digest_valid_out = 1'b1;
                digest_out       = hash_reg[cnt_reg];
                digest_last_out  = last_word;
                if (digest_ready_in && last_word) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_reg <= '0;
            hash_reg <= '0;
            mode_reg <= 1'b0;
            t_reg    <= '0;
            cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_in) begin
                        if (first_in) begin
                            mode_reg <= mode_in;
                            hash_reg <= iv_sel;
                            work_reg <= iv_sel;
                        end else begin
                            work_reg <= hash_reg;
                        end
                        t_reg <= '0;
                    end
                end
                ROUND: begin
                    if (w_valid_in) begin
                        work_reg <= chain[UNROLL];
                        t_reg    <= t_reg + 6'(UNROLL);
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        hash_reg[i] <= hash_reg[i] + work_reg[i];
                    end
                    cnt_reg <= '0;
                end
                SEND: begin
                    if (digest_ready_in && !last_word) cnt_reg <= cnt_reg + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
